// File: rtl/fir_codec_tx_buffer.sv
// -----------------------------------------------------------------------------
// fir_codec_tx_buffer
//
// Stereo sample buffer between the left/right FIR filter outputs and the audio
// CODEC write interface.
//   * Each {in_left,in_right} pair presented with in_valid is queued in a
//     DEPTH-entry FIFO.
//   * A three-process FSM drains the FIFO into an output register pair. It
//     issues one single-cycle write strobe per pair once write_ready is seen.
//   * Each sample is sign-preserving scaled to the CODEC's 24-bit word:
//     {sample, 8'h00}.
//   * A pair arriving while the FIFO is full, with no pop in the same cycle,
//     is dropped. The drop sets the sticky overflow flag.
//
// Optional feature (macro FIR_TX_DROP_COUNT_EN):
//   When this macro is defined, the output drop_count[7:0] is added. It counts
//   dropped pairs and saturates at 255. clr_status clears it. A drop in the
//   same cycle as clr_status leaves it at 1.
//
// Ports:
//   ck               system clock
//   rst_n            asynchronous active-low reset
//   in_left/right    signed 16-bit samples from the FIRs
//   in_valid         one-cycle strobe, pair valid this cycle
//   write_ready      CODEC can accept a pair
//   clr_status       synchronous clear of overflow (and drop_count)
//   write            one-cycle write strobe to the CODEC
//   writedata_left/right  24-bit CODEC words
//   level            pairs held in the FIFO (output register excluded)
//   overflow         sticky drop flag
//   drop_count       dropped-pair counter (FIR_TX_DROP_COUNT_EN only)
// -----------------------------------------------------------------------------
module fir_codec_tx_buffer #(
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          ck,
    input  logic          rst_n,
    input  logic [15:0]   in_left,
    input  logic [15:0]   in_right,
    input  logic          in_valid,
    input  logic          write_ready,
    input  logic          clr_status,
    output logic          write,
    output logic [23:0]   writedata_left,
    output logic [23:0]   writedata_right,
    output logic [LW-1:0] level,
    output logic          overflow
`ifdef FIR_TX_DROP_COUNT_EN
    ,
    output logic [7:0]    drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_SENT  = 2'b10
    } state_t;

    state_t          state_r;
    state_t          state_next_s;

    logic [31:0]     mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [LW-1:0]   count_r;

    logic            empty_s;
    logic            full_s;
    logic            load_s;
    logic            write_next_s;
    logic            push_s;
    logic            drop_s;
    logic [31:0]     head_s;

    // FIFO status and push/drop arbitration. A pop in the same cycle frees a slot.
    always_comb begin
        empty_s = (count_r == {LW{1'b0}});
        full_s  = (count_r == LW'(DEPTH));
        push_s  = in_valid & (~full_s | load_s);
        drop_s  = in_valid & full_s & ~load_s;
        head_s  = mem_r[rd_ptr_r];
    end

    // FSM state register.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_next_s = ST_ARMED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (write_ready) begin
                    state_next_s = ST_SENT;
                end else begin
                    state_next_s = ST_ARMED;
                end
            end
            ST_SENT: begin
                if (!empty_s) begin
                    state_next_s = ST_ARMED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: the FSM loads (pops) the head in IDLE or SENT and
    // strobes write after ARMED sees ready.
    always_comb begin
        load_s       = 1'b0;
        write_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_s = ~empty_s;
            end
            ST_ARMED: begin
                write_next_s = write_ready;
            end
            ST_SENT: begin
                load_s = ~empty_s;
            end
            default: begin
                load_s       = 1'b0;
                write_next_s = 1'b0;
            end
        endcase
    end

    // FIFO storage; contents need no reset because the pointers qualify them.
    always_ff @(posedge ck) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {in_left, in_right};
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (load_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, load_s})
                2'b10:   count_r <= count_r + LW'(1);
                2'b01:   count_r <= count_r - LW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign level = count_r;

    // Registered CODEC outputs. Each sample is scaled by 2^8, which keeps its sign bit.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            write           <= 1'b0;
            writedata_left  <= 24'h000000;
            writedata_right <= 24'h000000;
        end else begin
            write <= write_next_s;
            if (load_s) begin
                writedata_left  <= {head_s[31:16], 8'h00};
                writedata_right <= {head_s[15:0],  8'h00};
            end
        end
    end

    // Sticky overflow flag; a new drop takes priority over a clear.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop_s) begin
            overflow <= 1'b1;
        end else if (clr_status) begin
            overflow <= 1'b0;
        end else begin
            overflow <= overflow;
        end
    end

`ifdef FIR_TX_DROP_COUNT_EN
    // Saturating dropped-pair counter; a clear with a concurrent drop restarts at 1.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= 8'd0;
        end else if (clr_status) begin
            drop_count <= drop_s ? 8'd1 : 8'd0;
        end else if (drop_s && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end else begin
            drop_count <= drop_count;
        end
    end
`endif

endmodule

// File: tb/tb_fir_codec_tx_buffer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for fir_codec_tx_buffer (DEPTH = 8).
// Expected CODEC words come from plain signed arithmetic (sample * 256).
// Expected ordering comes from a queue of accepted pairs.
// -----------------------------------------------------------------------------
module tb_fir_codec_tx_buffer;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          ck;
    logic          rst_n;
    logic [15:0]   in_left;
    logic [15:0]   in_right;
    logic          in_valid;
    logic          write_ready;
    logic          clr_status;
    logic          write;
    logic [23:0]   writedata_left;
    logic [23:0]   writedata_right;
    logic [LW-1:0] level;
    logic          overflow;
`ifdef FIR_TX_DROP_COUNT_EN
    logic [7:0]    drop_count;
`endif

    int errors = 0;
    int checks = 0;

    fir_codec_tx_buffer #(.DEPTH(DEPTH)) dut (
        .ck              (ck),
        .rst_n           (rst_n),
        .in_left         (in_left),
        .in_right        (in_right),
        .in_valid        (in_valid),
        .write_ready     (write_ready),
        .clr_status      (clr_status),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .level           (level),
        .overflow        (overflow)
`ifdef FIR_TX_DROP_COUNT_EN
        ,
        .drop_count      (drop_count)
`endif
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    // Reference conversion: the 24-bit two's complement value sample * 2^8.
    function automatic logic [23:0] scale(input logic [15:0] s);
        int v;
        v = int'($signed(s)) * 256;
        return v[23:0];
    endfunction

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; write_ready = 1'b0; clr_status = 1'b0;
        in_left = 16'h0000; in_right = 16'h0000;
        tick(); tick();
        checks++;
        if ({write, writedata_left, writedata_right, level, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_state: got w=%0b l=%0h r=%0h lvl=%0d ovf=%0b expected all zero",
                     write, writedata_left, writedata_right, level, overflow);
        end
        @(negedge ck);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({write, level, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_release: got w=%0b lvl=%0d ovf=%0b expected 0 0 0", write, level, overflow);
        end
    endtask

    task automatic test_latency();
        int nw;
        write_ready = 1'b1;
        in_left = 16'h1234; in_right = 16'hFEDC; in_valid = 1'b1;
        tick();                       // edge k
        in_valid = 1'b0;
        checks++;
        if (level !== LW'(1) || write !== 1'b0) begin
            errors++; $display("FAIL lat_k: got lvl=%0d w=%0b expected 1 0", level, write);
        end
        tick();                       // edge k+1: head loaded
        checks++;
        if (write !== 1'b0 || level !== LW'(0)) begin
            errors++; $display("FAIL lat_k1: got w=%0b lvl=%0d expected 0 0", write, level);
        end
        tick();                       // edge k+2: write high during cycle k+3
        checks++;
        if (write !== 1'b1 || writedata_left !== 24'h123400 || writedata_right !== 24'hFEDC00) begin
            errors++;
            $display("FAIL lat_write: got w=%0b l=%0h r=%0h expected 1 123400 fedc00",
                     write, writedata_left, writedata_right);
        end
        nw = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (write) nw++;
        end
        checks++;
        if (nw != 0) begin
            errors++; $display("FAIL lat_single: got %0d extra writes expected 0", nw);
        end
    endtask

    task automatic test_fill_drain();
        int nw;
        int cyc [16];
        logic [23:0] dl [16];
        logic [23:0] dr [16];
        write_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_left = 16'(i); in_right = 16'h0000 - 16'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        // Pair 1 sits in the output register, so the FIFO holds the other 7.
        checks++;
        if (level !== LW'(7) || write !== 1'b0) begin
            errors++; $display("FAIL fill_level: got lvl=%0d w=%0b expected 7 0", level, write);
        end
        write_ready = 1'b1;
        nw = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (write && nw < 16) begin
                cyc[nw] = c; dl[nw] = writedata_left; dr[nw] = writedata_right; nw++;
            end
        end
        checks++;
        if (nw != 8) begin
            errors++; $display("FAIL drain_count: got %0d writes expected 8", nw);
        end
        for (int i = 0; i < 8 && i < nw; i++) begin
            checks++;
            if (dl[i] !== scale(16'(i + 1)) || dr[i] !== scale(16'h0000 - 16'(i + 1))) begin
                errors++;
                $display("FAIL drain_data[%0d]: got %0h/%0h expected %0h/%0h", i, dl[i], dr[i],
                         scale(16'(i + 1)), scale(16'h0000 - 16'(i + 1)));
            end
            if (i > 0) begin
                checks++;
                if (cyc[i] - cyc[i-1] != 2) begin
                    errors++; $display("FAIL drain_spacing[%0d]: got %0d cycles expected 2", i, cyc[i] - cyc[i-1]);
                end
            end
        end
        checks++;
        if (level !== LW'(0)) begin
            errors++; $display("FAIL drain_level: got %0d expected 0", level);
        end
    endtask

    task automatic test_overflow();
        write_ready = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            in_left = 16'h0100 + 16'(i); in_right = ~(16'h0100 + 16'(i)); in_valid = 1'b1;
            tick();
            if (i == 9) begin
                checks++;
                if (level !== LW'(8) || overflow !== 1'b0) begin
                    errors++; $display("FAIL full_no_drop: got lvl=%0d ovf=%0b expected 8 0", level, overflow);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (level !== LW'(8) || overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_set: got lvl=%0d ovf=%0b expected 8 1", level, overflow);
        end
`ifdef FIR_TX_DROP_COUNT_EN
        checks++;
        if (drop_count !== 8'd2) begin
            errors++; $display("FAIL drop_count2: got %0d expected 2", drop_count);
        end
`endif
        tick();
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_sticky: got %0b expected 1", overflow);
        end
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL overflow_clear: got %0b expected 0", overflow);
        end
`ifdef FIR_TX_DROP_COUNT_EN
        checks++;
        if (drop_count !== 8'd0) begin
            errors++; $display("FAIL drop_count_clear: got %0d expected 0", drop_count);
        end
`endif
        // A clear and a drop in the same cycle: the drop wins.
        in_left = 16'h0DDD; in_right = 16'h0EEE; in_valid = 1'b1; clr_status = 1'b1;
        tick();
        in_valid = 1'b0; clr_status = 1'b0;
        checks++;
        if (overflow !== 1'b1 || level !== LW'(8)) begin
            errors++; $display("FAIL clr_vs_drop: got ovf=%0b lvl=%0d expected 1 8", overflow, level);
        end
`ifdef FIR_TX_DROP_COUNT_EN
        checks++;
        if (drop_count !== 8'd1) begin
            errors++; $display("FAIL drop_count_clr_drop: got %0d expected 1", drop_count);
        end
`endif
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL overflow_clear2: got %0b expected 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp_l [$];
        int nw;
        // State: pair 0x0101 is armed and pairs 0x0102..0x0109 fill the FIFO.
        write_ready = 1'b1;
        tick();
        checks++;
        if (write !== 1'b1 || writedata_left !== scale(16'h0101)) begin
            errors++; $display("FAIL fpp_first: got w=%0b l=%0h expected 1 %0h", write, writedata_left, scale(16'h0101));
        end
        // The SENT cycle pops the next head, so a push in the same cycle is accepted.
        write_ready = 1'b0;
        in_left = 16'h01AA; in_right = 16'h0155; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (level !== LW'(8) || overflow !== 1'b0 || write !== 1'b0) begin
            errors++; $display("FAIL fpp_no_drop: got lvl=%0d ovf=%0b w=%0b expected 8 0 0", level, overflow, write);
        end
        for (int i = 2; i <= 9; i++) exp_l.push_back(16'h0100 + 16'(i));
        exp_l.push_back(16'h01AA);
        write_ready = 1'b1;
        nw = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (write) begin
                nw++;
                checks++;
                if (exp_l.size() == 0) begin
                    errors++; $display("FAIL fpp_extra: got unexpected write l=%0h expected none", writedata_left);
                end else begin
                    if (writedata_left !== scale(exp_l[0])) begin
                        errors++; $display("FAIL fpp_order: got %0h expected %0h", writedata_left, scale(exp_l[0]));
                    end
                    void'(exp_l.pop_front());
                end
            end
        end
        checks++;
        if (nw != 9 || level !== LW'(0)) begin
            errors++; $display("FAIL fpp_drain: got %0d writes lvl=%0d expected 9 0", nw, level);
        end
    endtask

    task automatic test_async_reset();
        int nw;
        write_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_left = 16'h0200 + 16'(i); in_right = 16'h0300 + 16'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        write_ready = 1'b1;
        tick();
        checks++;
        if (write !== 1'b1 || level !== LW'(5)) begin
            errors++; $display("FAIL arst_pre: got w=%0b lvl=%0d expected 1 5", write, level);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (write !== 1'b0 || level !== LW'(0) || writedata_left !== 24'h0 || writedata_right !== 24'h0) begin
            errors++;
            $display("FAIL arst_immediate: got w=%0b lvl=%0d l=%0h r=%0h expected 0 0 0 0",
                     write, level, writedata_left, writedata_right);
        end
        #3 rst_n = 1'b1;
        nw = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (write) nw++;
        end
        checks++;
        if (nw != 0 || level !== LW'(0)) begin
            errors++; $display("FAIL arst_stale: got %0d writes lvl=%0d expected 0 0", nw, level);
        end
    endtask

    task automatic test_neg_fullscale();
        int nw;
        write_ready = 1'b0;
        in_left = 16'h8000; in_right = 16'h7FFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (write !== 1'b0 || writedata_left !== 24'h800000 || writedata_right !== scale(16'h7FFF)) begin
            errors++;
            $display("FAIL neg_fullscale: got w=%0b l=%0h r=%0h expected 0 800000 %0h",
                     write, writedata_left, writedata_right, scale(16'h7FFF));
        end
        write_ready = 1'b1;
        tick();
        write_ready = 1'b0;
        nw = write ? 1 : 0;
        for (int c = 0; c < 6; c++) begin
            write_ready = (c == 2) ? 1'b1 : 1'b0;
            tick();
            if (write) nw++;
        end
        checks++;
        if (nw != 1) begin
            errors++; $display("FAIL ready_toggle: got %0d writes expected 1", nw);
        end
    endtask

    task automatic test_random_stream();
        logic [31:0] q [$];
        int pushed;
        int written;
        logic prev_w;
        logic [15:0] l;
        logic [15:0] r;
        pushed = 0; written = 0; prev_w = 1'b0;
        for (int c = 0; c < 1200; c++) begin
            if (c < 900) begin
                write_ready = 1'($urandom_range(0, 1));
                if ((pushed - written) < DEPTH && $urandom_range(0, 2) == 0) begin
                    l = 16'($urandom); r = 16'($urandom);
                    in_left = l; in_right = r; in_valid = 1'b1;
                    q.push_back({l, r});
                    pushed++;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                write_ready = 1'b1; in_valid = 1'b0;
            end
            tick();
            in_valid = 1'b0;
            if (write) begin
                written++;
                checks++;
                if (prev_w) begin
                    errors++; $display("FAIL rnd_pulse_width: got write high two cycles expected one");
                end else if (q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra_write: got write l=%0h expected none", writedata_left);
                end else begin
                    if (writedata_left !== scale(q[0][31:16]) || writedata_right !== scale(q[0][15:0])) begin
                        errors++;
                        $display("FAIL rnd_data: got %0h/%0h expected %0h/%0h", writedata_left, writedata_right,
                                 scale(q[0][31:16]), scale(q[0][15:0]));
                    end
                    void'(q.pop_front());
                end
            end
            prev_w = write;
            if (level > LW'(DEPTH) || overflow !== 1'b0) begin
                checks++;
                errors++; $display("FAIL rnd_level: got lvl=%0d ovf=%0b expected <=%0d 0", level, overflow, DEPTH);
            end
        end
        checks++;
        if (q.size() != 0 || level !== LW'(0) || pushed < 50) begin
            errors++; $display("FAIL rnd_final: got %0d pending lvl=%0d pushed=%0d expected 0 0 >=50", q.size(), level, pushed);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_async_reset();
        test_neg_fullscale();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
